rv_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RISC-V processor datapath.
- Accepts one instruction at a time over a valid/ready handshake and holds it in an instruction register.
- Steps the datapath through FETCH/DECODE/EXEC/MEM/WB, driving its enables and owning the program counter.
- Flags illegal opcodes and data-memory timeouts.

---
 rtl/rv_multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RISC-V control sequencer: holds one instruction at a time, steps the
// datapath through DECODE/EXEC/MEM/WB, owns the PC and flags illegal ops / memory timeouts.
module rv_multicycle_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_instr_valid,
  input  logic [31:0] i_instr,
  output logic        o_instr_ready,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc,
  input  logic        i_branch_taken,
  input  logic [31:0] i_target,
  output logic        o_alu_en,
  output logic        o_mem_req,
  output logic        o_mem_we,
  input  logic        i_mem_ack,
  output logic        o_rf_we,
  output logic        o_retired,
  output logic        o_illegal,
  output logic        o_mem_err
);

  // state    | meaning
  // S_FETCH  | waiting for an instruction handshake
  // S_DECODE | classify opcode held in o_ir
  // S_EXEC   | ALU capture, branch resolve, JAL target capture
  // S_MEM    | data-memory request outstanding, timeout counting
  // S_WB     | register writeback and PC advance
  // S_TRAP   | report illegal opcode or memory timeout, skip instruction
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [7:0] TO_LAST    = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_jal_tgt;
  logic        r_cause_mem;

  logic        w_is_alu;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_legal;
  logic [31:0] w_pc_inc;

  assign w_is_alu    = (o_ir[6:0] == OPC_OP_IMM) || (o_ir[6:0] == OPC_OP) ||
                       (o_ir[6:0] == OPC_LUI);
  assign w_is_load   = (o_ir[6:0] == OPC_LOAD);
  assign w_is_store  = (o_ir[6:0] == OPC_STORE);
  assign w_is_branch = (o_ir[6:0] == OPC_BRANCH);
  assign w_is_jal    = (o_ir[6:0] == OPC_JAL);
  assign w_legal     = w_is_alu || w_is_load || w_is_store || w_is_branch || w_is_jal;
  assign w_pc_inc    = o_pc + 32'd4;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      o_pc        <= RESET_PC;
      o_ir        <= '0;
      r_cnt       <= '0;
      r_jal_tgt   <= '0;
      r_cause_mem <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_instr_valid) begin
            o_ir    <= i_instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_cause_mem <= 1'b0;
            r_state     <= S_TRAP;
          end
        end
        S_EXEC: begin
          if (w_is_jal) r_jal_tgt <= i_target;
          if (w_is_load || w_is_store) begin
            r_cnt   <= '0;
            r_state <= S_MEM;
          end else if (w_is_branch) begin
            o_pc    <= i_branch_taken ? i_target : w_pc_inc;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          // an ack on the last allowed cycle still wins over the timeout
          if (i_mem_ack) begin
            if (w_is_store) begin
              o_pc    <= w_pc_inc;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end else if (r_cnt == TO_LAST) begin
            r_cause_mem <= 1'b1;
            r_state     <= S_TRAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WB: begin
          o_pc    <= w_is_jal ? r_jal_tgt : w_pc_inc;
          r_state <= S_FETCH;
        end
        S_TRAP: begin
          o_pc    <= w_pc_inc;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign o_instr_ready = (r_state == S_FETCH) && !rst;
  assign o_alu_en      = (r_state == S_EXEC);
  assign o_mem_req     = (r_state == S_MEM);
  assign o_mem_we      = (r_state == S_MEM) && w_is_store;
  assign o_rf_we       = (r_state == S_WB) && (o_ir[11:7] != 5'd0);
  assign o_retired     = (r_state == S_WB) ||
                         ((r_state == S_EXEC) && w_is_branch) ||
                         ((r_state == S_MEM) && w_is_store && i_mem_ack);
  assign o_illegal     = (r_state == S_TRAP) && !r_cause_mem;
  assign o_mem_err     = (r_state == S_TRAP) && r_cause_mem;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Bench for rv_multicycle_ctrl: table vectors, corner sequences and random instructions
// checked cycle by cycle against a per-instruction-class timeline model.
module tb_rv_multicycle_ctrl;

  localparam int MEM_TO = 15;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic        i_clk = 1'b0;
  logic        rst;
  logic        i_instr_valid;
  logic [31:0] i_instr;
  logic        o_instr_ready;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        i_branch_taken;
  logic [31:0] i_target;
  logic        o_alu_en;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        i_mem_ack;
  logic        o_rf_we;
  logic        o_retired;
  logic        o_illegal;
  logic        o_mem_err;

  always #5 i_clk = ~i_clk;

  rv_multicycle_ctrl #(.RESET_PC(32'h0000_0000), .MEM_TIMEOUT(MEM_TO)) dut (
    .i_clk(i_clk), .rst(rst),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr), .o_instr_ready(o_instr_ready),
    .o_ir(o_ir), .o_pc(o_pc),
    .i_branch_taken(i_branch_taken), .i_target(i_target),
    .o_alu_en(o_alu_en), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .i_mem_ack(i_mem_ack),
    .o_rf_we(o_rf_we), .o_retired(o_retired), .o_illegal(o_illegal), .o_mem_err(o_mem_err)
  );

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] model_pc;

  typedef struct packed {
    logic [7:0] v;
    logic       mem;
    logic       ack;
  } step_t;

  typedef struct {
    logic [31:0] instr;
    logic        taken;
    logic [31:0] tgt;
    int          ack_dly;
    logic [31:0] exp_pc;
    int          exp_req;
    int          exp_rf;
    int          exp_ret;
    int          exp_ill;
    int          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // strobe vector order: ready, alu_en, mem_req, mem_we, rf_we, retired, illegal, mem_err
  function automatic logic [7:0] strobes();
    return {o_instr_ready, o_alu_en, o_mem_req, o_mem_we, o_rf_we, o_retired, o_illegal, o_mem_err};
  endfunction

  // Entered and left 1ns after a rising edge with the controller in FETCH.
  task automatic run_instr(input logic [31:0] instr, input logic taken, input logic [31:0] tgt,
                           input int ack_dly, input int idle,
                           output int c_req, output int c_rf, output int c_ret,
                           output int c_ill, output int c_merr);
    step_t       sq[$];
    logic [6:0]  op;
    logic [7:0]  wb;
    logic [7:0]  we;
    logic [7:0]  v;
    logic [31:0] npc;
    op = instr[6:0];
    wb = (instr[11:7] != 5'd0) ? 8'h0C : 8'h04;
    we = (op == OPC_STORE) ? 8'h10 : 8'h00;
    npc = model_pc + 32'd4;
    sq.push_back(step_t'({8'h00, 1'b0, 1'b0}));
    case (op)
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_JAL: begin
        sq.push_back(step_t'({8'h40, 1'b0, 1'b0}));
        sq.push_back(step_t'({wb, 1'b0, 1'b0}));
        if (op == OPC_JAL) npc = tgt;
      end
      OPC_BRANCH: begin
        sq.push_back(step_t'({8'h44, 1'b0, 1'b0}));
        if (taken) npc = tgt;
      end
      OPC_LOAD, OPC_STORE: begin
        sq.push_back(step_t'({8'h40, 1'b0, 1'b0}));
        if (ack_dly < MEM_TO) begin
          for (int m = 0; m <= ack_dly; m++) begin
            v = 8'h20 | we;
            if (op == OPC_STORE && m == ack_dly) v = v | 8'h04;
            sq.push_back(step_t'({v, 1'b1, (m == ack_dly)}));
          end
          if (op == OPC_LOAD) sq.push_back(step_t'({wb, 1'b0, 1'b0}));
        end else begin
          for (int m = 0; m < MEM_TO; m++) sq.push_back(step_t'({8'h20 | we, 1'b1, 1'b0}));
          sq.push_back(step_t'({8'h01, 1'b0, 1'b0}));
        end
      end
      default: sq.push_back(step_t'({8'h02, 1'b0, 1'b0}));
    endcase

    c_req = 0; c_rf = 0; c_ret = 0; c_ill = 0; c_merr = 0;
    for (int k = 0; k < idle; k++) begin
      i_instr_valid = 1'b0;
      i_instr = $urandom;
      i_mem_ack = 1'($urandom % 2);
      #3;
      check("idle_strobes", 32'(strobes()), 32'h80);
      @(posedge i_clk); #1;
    end
    i_instr_valid = 1'b1;
    i_instr = instr;
    i_branch_taken = taken;
    i_target = tgt;
    i_mem_ack = 1'($urandom % 2);
    #3;
    check("fetch_strobes", 32'(strobes()), 32'h80);
    check("fetch_pc", o_pc, model_pc);
    @(posedge i_clk); #1;
    for (int k = 0; k < sq.size(); k++) begin
      i_instr_valid = 1'($urandom % 2);
      i_instr = $urandom;
      i_mem_ack = sq[k].mem ? sq[k].ack : 1'($urandom % 2);
      #3;
      v = strobes();
      check($sformatf("strobes op=%02h cyc=%0d", op, k), 32'(v), 32'(sq[k].v));
      check("pc_hold", o_pc, model_pc);
      if (k == 0) check("ir_latch", o_ir, instr);
      c_req += int'(v[5]); c_rf += int'(v[3]); c_ret += int'(v[2]);
      c_ill += int'(v[1]); c_merr += int'(v[0]);
      @(posedge i_clk); #1;
    end
    i_instr_valid = 1'b0;
    i_mem_ack = 1'b0;
    model_pc = npc;
    check("pc_next", o_pc, model_pc);
    check("ir_hold", o_ir, instr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r_req, r_rf, r_ret, r_ill, r_merr;
    logic [31:0] ins;
    logic [6:0]  op;

    //        instr         tk    target        dly  exp_pc        req rf ret ill err
    tbl.push_back('{32'h00000013, 1'b0, 32'h0,        0,   32'h04,  0, 0, 1, 0, 0});
    tbl.push_back('{32'h00500093, 1'b0, 32'h0,        0,   32'h08,  0, 1, 1, 0, 0});
    tbl.push_back('{32'h00208463, 1'b0, 32'h10,       0,   32'h0C,  0, 0, 1, 0, 0});
    tbl.push_back('{32'h0000006F, 1'b0, 32'h08,       0,   32'h08,  0, 0, 1, 0, 0});
    tbl.push_back('{32'h00208463, 1'b1, 32'h10,       0,   32'h10,  0, 0, 1, 0, 0});
    tbl.push_back('{32'h0000A103, 1'b0, 32'h0,        3,   32'h14,  4, 1, 1, 0, 0});
    tbl.push_back('{32'h0020A023, 1'b0, 32'h0,        0,   32'h18,  1, 0, 1, 0, 0});
    tbl.push_back('{32'hFFFFFFFF, 1'b0, 32'h0,        0,   32'h1C,  0, 0, 0, 1, 0});
    tbl.push_back('{32'h0000A103, 1'b0, 32'h0,        255, 32'h20, 15, 0, 0, 0, 1});
    tbl.push_back('{32'h123450B7, 1'b0, 32'h0,        0,   32'h24,  0, 1, 1, 0, 0});
    tbl.push_back('{32'h002081B3, 1'b0, 32'h0,        0,   32'h28,  0, 1, 1, 0, 0});
    tbl.push_back('{32'h00000073, 1'b0, 32'h0,        0,   32'h2C,  0, 0, 0, 1, 0});
    tbl.push_back('{32'h0020A023, 1'b0, 32'h0,        2,   32'h30,  3, 0, 1, 0, 0});
    tbl.push_back('{32'h0000A103, 1'b0, 32'h0,        14,  32'h34, 15, 1, 1, 0, 0});
    tbl.push_back('{32'h004000EF, 1'b0, 32'h100,      0,   32'h100, 0, 1, 1, 0, 0});

    rst = 1'b1;
    i_instr_valid = 1'b0;
    i_instr = '0;
    i_branch_taken = 1'b0;
    i_target = '0;
    i_mem_ack = 1'b0;
    #12;
    check("reset_strobes", 32'(strobes()), 32'h00);
    check("reset_pc", o_pc, 32'h0);
    check("reset_ir", o_ir, 32'h0);
    @(posedge i_clk); #1;
    rst = 1'b0;
    #3;
    check("ready_after_reset", 32'(strobes()), 32'h80);
    @(posedge i_clk); #1;
    model_pc = 32'h0;

    foreach (tbl[i]) begin
      run_instr(tbl[i].instr, tbl[i].taken, tbl[i].tgt, tbl[i].ack_dly, i % 3,
                r_req, r_rf, r_ret, r_ill, r_merr);
      check($sformatf("tbl%0d_pc", i), o_pc, tbl[i].exp_pc);
      check($sformatf("tbl%0d_req_cycles", i), 32'(r_req), 32'(tbl[i].exp_req));
      check($sformatf("tbl%0d_rf_we", i), 32'(r_rf), 32'(tbl[i].exp_rf));
      check($sformatf("tbl%0d_retired", i), 32'(r_ret), 32'(tbl[i].exp_ret));
      check($sformatf("tbl%0d_illegal", i), 32'(r_ill), 32'(tbl[i].exp_ill));
      check($sformatf("tbl%0d_mem_err", i), 32'(r_merr), 32'(tbl[i].exp_err));
    end

    // PC wraps modulo 2^32
    run_instr(32'h0000006F, 1'b0, 32'hFFFF_FFFC, 0, 0, r_req, r_rf, r_ret, r_ill, r_merr);
    check("pc_at_top", o_pc, 32'hFFFF_FFFC);
    run_instr(32'h00000013, 1'b0, 32'h0, 0, 1, r_req, r_rf, r_ret, r_ill, r_merr);
    check("pc_wrap", o_pc, 32'h0);

    // reset asserted while a store is in MEM
    i_instr_valid = 1'b1;
    i_instr = 32'h0020A023;
    i_mem_ack = 1'b0;
    @(posedge i_clk); #1;
    i_instr_valid = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("mid_mem_req", 32'(o_mem_req), 32'h1);
    check("mid_mem_we", 32'(o_mem_we), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_req_drop", 32'(o_mem_req), 32'h0);
    check("rst_strobes", 32'(strobes()), 32'h00);
    check("rst_pc", o_pc, 32'h0);
    check("rst_ir", o_ir, 32'h0);
    i_mem_ack = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ack = 1'b0;
    rst = 1'b0;
    #2;
    check("rst_release_strobes", 32'(strobes()), 32'h80);
    @(posedge i_clk); #1;
    check("rst_release_pc", o_pc, 32'h0);
    check("rst_release_ready", 32'(strobes()), 32'h80);
    model_pc = 32'h0;
    run_instr(32'h00500093, 1'b0, 32'h0, 0, 0, r_req, r_rf, r_ret, r_ill, r_merr);
    check("post_rst_pc", o_pc, 32'h4);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 8))
        0: op = OPC_OP_IMM;
        1: op = OPC_OP;
        2: op = OPC_LUI;
        3: op = OPC_LOAD;
        4: op = OPC_STORE;
        5: op = OPC_BRANCH;
        6: op = OPC_JAL;
        default: op = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0] = op;
      run_instr(ins, 1'($urandom % 2), $urandom, int'($urandom_range(0, 17)),
                int'($urandom_range(0, 2)), r_req, r_rf, r_ret, r_ill, r_merr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
